// File: rtl/tensor_replay_buffer_if.sv
// Beat-level handshake bundle for the tensor replay buffer.
// The slave side is the buffer; the master side is the producer/consumer.
interface tensor_replay_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_NUM     = 4,
   parameter int REPEAT     = 2
);
   localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   logic [DATA_WIDTH-1:0] data_in [IN_NUM];
   logic                  data_in_valid;
   logic                  data_in_ready;
   logic [DATA_WIDTH-1:0] data_out [IN_NUM];
   logic                  data_out_valid;
   logic                  data_out_ready;
   logic                  data_out_last;
   logic [PASS_W-1:0]     data_out_pass;

   modport slave (
      input  data_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, data_out_valid,
      output data_out_last, data_out_pass
   );

   modport master (
      output data_in, data_in_valid, data_out_ready,
      input  data_in_ready, data_out, data_out_valid,
      input  data_out_last, data_out_pass
   );
endinterface

// File: rtl/tensor_replay_buffer.sv
// Stores one DEPTH-beat tensor, then replays it REPEAT times.
// Input is back-pressured while the stored tensor drains.
module tensor_replay_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_NUM     = 4,
   parameter int DEPTH      = 4,
   parameter int REPEAT     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   tensor_replay_buffer_if.slave bus
);
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t              state;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [PASS_W-1:0]   pass;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                last_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH][IN_NUM];

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_ready_q & bus.data_in_valid;
   assign out_xfer = out_valid_q & bus.data_out_ready;

   assign bus.data_in_ready  = in_ready_q;
   assign bus.data_out_valid = out_valid_q;
   assign bus.data_out_last  = last_q;
   assign bus.data_out_pass  = pass;
   assign bus.data_out       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (in_xfer) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   // in_ready_q stays low in reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FILL;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pass        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               in_ready_q <= 1'b1;
               if (in_xfer) begin
                  if (wr_ptr == PW'(DEPTH - 1)) begin
                     wr_ptr      <= '0;
                     state       <= DRAIN;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     last_q      <= (DEPTH == 1);
                  end else begin
                     wr_ptr <= wr_ptr + PW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_xfer) begin
                  if (rd_ptr == PW'(DEPTH - 1)) begin
                     rd_ptr <= '0;
                     last_q <= (DEPTH == 1);
                     if (pass == PASS_W'(REPEAT - 1)) begin
                        pass        <= '0;
                        state       <= FILL;
                        out_valid_q <= 1'b0;
                        last_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                     end else begin
                        pass <= pass + PASS_W'(1);
                     end
                  end else begin
                     rd_ptr <= rd_ptr + PW'(1);
                     last_q <= (rd_ptr == PW'(DEPTH - 2));
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_tensor_replay_buffer.sv
// Directed bench for tensor_replay_buffer: 4x2x3 build plus a 1x1 build.
// Expected beats come from a table built from the fill values.
module tb_tensor_replay_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tensor_replay_buffer_if #(.DATA_WIDTH(16), .IN_NUM(2), .REPEAT(3)) if0 ();
   tensor_replay_buffer_if #(.DATA_WIDTH(16), .IN_NUM(2), .REPEAT(1)) if1 ();

   tensor_replay_buffer #(
      .DATA_WIDTH(16), .IN_NUM(2), .DEPTH(4), .REPEAT(3)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );

   tensor_replay_buffer #(
      .DATA_WIDTH(16), .IN_NUM(2), .DEPTH(1), .REPEAT(1)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   typedef struct {
      int d0;
      int d1;
      int last;
      int pass;
   } exp_t;

   exp_t tbl [12];
   int fa [4];
   int fb [4];
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build();
      for (int k = 0; k < 12; k++) begin
         tbl[k].d0   = fa[k % 4];
         tbl[k].d1   = fb[k % 4];
         tbl[k].last = ((k % 4) == 3) ? 1 : 0;
         tbl[k].pass = k / 4;
      end
   endtask

   task automatic fill();
      for (int i = 0; i < 4; i++) begin
         chk("fill_ready", int'(if0.data_in_ready), 1);
         if0.data_in[0]   = 16'(fa[i]);
         if0.data_in[1]   = 16'(fb[i]);
         if0.data_in_valid = 1'b1;
         tick();
      end
      if0.data_in_valid = 1'b0;
      build();
   endtask

   task automatic chk_beat(input int k);
      chk("out_valid", int'(if0.data_out_valid), 1);
      chk("in_ready_lo", int'(if0.data_in_ready), 0);
      chk("d0", int'(if0.data_out[0]), tbl[k].d0);
      chk("d1", int'(if0.data_out[1]), tbl[k].d1);
      chk("last", int'(if0.data_out_last), tbl[k].last);
      chk("pass", int'(if0.data_out_pass), tbl[k].pass);
   endtask

   task automatic drain_from(input int k0);
      if0.data_out_ready = 1'b1;
      for (int k = k0; k < 12; k++) begin
         chk_beat(k);
         tick();
      end
      chk("drain_done_valid", int'(if0.data_out_valid), 0);
      chk("drain_done_ready", int'(if0.data_in_ready), 1);
   endtask

   initial begin
      int idx;
      int outx;
      int n;
      bit r;
      bit done;

      if0.data_in_valid  = 1'b0;
      if0.data_out_ready = 1'b1;
      if0.data_in[0] = '0;
      if0.data_in[1] = '0;
      if1.data_in_valid  = 1'b0;
      if1.data_out_ready = 1'b1;
      if1.data_in[0] = '0;
      if1.data_in[1] = '0;

      #1;
      chk("rst_in_ready", int'(if0.data_in_ready), 0);
      chk("rst_out_valid", int'(if0.data_out_valid), 0);
      chk("rst_last", int'(if0.data_out_last), 0);
      chk("rst_pass", int'(if0.data_out_pass), 0);
      tick();
      rst = 1'b1;
      #1;
      chk("rel_ready_lo", int'(if0.data_in_ready), 0);
      tick();
      chk("rel_ready_hi", int'(if0.data_in_ready), 1);

      fa = '{1, 3, 5, 7};
      fb = '{2, 4, 6, 8};
      fill();
      drain_from(0);

      chk("d1_ready", int'(if1.data_in_ready), 1);
      if1.data_in[0] = 16'd42;
      if1.data_in[1] = 16'd43;
      if1.data_in_valid = 1'b1;
      if1.data_out_ready = 1'b0;
      tick();
      if1.data_in_valid = 1'b0;
      chk("d1_valid", int'(if1.data_out_valid), 1);
      chk("d1_last", int'(if1.data_out_last), 1);
      chk("d1_d0", int'(if1.data_out[0]), 42);
      chk("d1_d1", int'(if1.data_out[1]), 43);
      chk("d1_pass", int'(if1.data_out_pass), 0);
      chk("d1_in_lo", int'(if1.data_in_ready), 0);
      if1.data_out_ready = 1'b1;
      tick();
      chk("d1_valid_lo", int'(if1.data_out_valid), 0);
      chk("d1_fill", int'(if1.data_in_ready), 1);

      fill();
      idx = 0;
      r = 1'b0;
      for (int cyc = 0; cyc < 60 && idx < 12; cyc++) begin
         chk_beat(idx);
         if0.data_out_ready = r;
         tick();
         if (r) idx++;
         r = ~r;
      end
      if (idx < 12) chk("stall_timeout", idx, 12);
      if0.data_out_ready = 1'b1;
      chk("stall_done", int'(if0.data_out_valid), 0);

      n = 1;
      outx = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if0.data_in[0] = 16'(n);
         if0.data_in[1] = 16'(n + 100);
         if0.data_in_valid = 1'b1;
         if (if0.data_out_valid) begin
            chk("hold_ready_lo", int'(if0.data_in_ready), 0);
            chk("hold_d0", int'(if0.data_out[0]), (outx % 4) + 1);
            chk("hold_d1", int'(if0.data_out[1]), (outx % 4) + 101);
            outx++;
         end
         if (if0.data_in_ready) begin
            if (n == 5) begin
               chk("hold_xfers", outx, 12);
               chk("hold_ovalid", int'(if0.data_out_valid), 0);
               done = 1'b1;
            end
            n++;
         end
         tick();
      end
      if (!done) chk("hold_timeout", n, 6);
      if0.data_in_valid = 1'b0;

      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      for (int i = 1; i <= 2; i++) begin
         if0.data_in[0] = 16'(i);
         if0.data_in[1] = 16'(i);
         if0.data_in_valid = 1'b1;
         tick();
      end
      if0.data_in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_fill_ready", int'(if0.data_in_ready), 0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_fill_rel", int'(if0.data_in_ready), 1);
      fa = '{9, 10, 11, 12};
      fb = '{9, 10, 11, 12};
      fill();
      drain_from(0);

      fa = '{21, 22, 23, 24};
      fb = '{31, 32, 33, 34};
      fill();
      for (int k = 0; k < 5; k++) begin
         chk_beat(k);
         tick();
      end
      chk("mid_drain_pass", int'(if0.data_out_pass), 1);
      rst = 1'b0;
      #1;
      chk("md_valid", int'(if0.data_out_valid), 0);
      chk("md_last", int'(if0.data_out_last), 0);
      chk("md_pass", int'(if0.data_out_pass), 0);
      chk("md_ready", int'(if0.data_in_ready), 0);
      tick();
      rst = 1'b1;
      #1;
      chk("md_rel_lo", int'(if0.data_in_ready), 0);
      tick();
      chk("md_rel_hi", int'(if0.data_in_ready), 1);
      fa = '{51, 52, 53, 54};
      fb = '{61, 62, 63, 64};
      fill();
      drain_from(0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
